jk_excite_driver: RTL
=====================

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of JK flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 3, range 0..6, sets the re-drive attempts after the first.
REQ-003 Parameter USE_TOGGLE, default 0; when 1, changed bits SHALL be driven with J=K=1.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  target request valid.
REQ-007 req_ready  output  1  block idle and able to accept.
REQ-008 target  input  WIDTH  desired flop bank value.
REQ-009 q_fb  input  WIDTH  Q outputs fed back from the driven flop bank.
REQ-010 j  output  WIDTH  J inputs to the flop bank.
REQ-011 k  output  WIDTH  K inputs to the flop bank.
REQ-012 done  output  1  one-cycle pulse: q_fb matched target.
REQ-013 err  output  1  one-cycle pulse: retries exhausted without a match.
REQ-014 attempts  output  3  number of drive cycles used by the last request; held until the next accept.

Function
REQ-015 States SHALL be IDLE, DRIVE and CHECK; req_ready SHALL equal (state==IDLE), decoded combinationally from state.
REQ-016 Accept occurs on a rising edge with req_valid=1 in IDLE; target SHALL be latched, attempts set to 1, and the state set to DRIVE.
REQ-017 At accept and at each retry, j/k SHALL be registered from q_fb and the latched target: bits needing 0->1 get j=1,k=0; bits needing 1->0 get j=0,k=1; unchanged bits get j=0,k=0.
REQ-018 With USE_TOGGLE=1, every changed bit SHALL instead get j=1,k=1, and unchanged bits SHALL get j=0,k=0.
REQ-019 j/k SHALL be nonzero only during the DRIVE cycle; on leaving DRIVE they SHALL be cleared to 0 (hold), and the state SHALL become CHECK.
REQ-020 In CHECK, if q_fb==target, the next edge SHALL set the state to IDLE and pulse done for exactly one cycle.
REQ-021 In CHECK, on a mismatch with attempts<=MAX_RETRY, the next edge SHALL recompute j/k per REQ-017/018, increment attempts, and set the state to DRIVE.
REQ-022 In CHECK, on a mismatch with attempts==MAX_RETRY+1, the next edge SHALL set the state to IDLE and pulse err for exactly one cycle.
REQ-023 Latency SHALL be fixed: done or err is high in the cycle starting 2*attempts edges after the accept edge.
REQ-024 target==q_fb at accept SHALL still perform one DRIVE cycle with j=k=0 and end in done with attempts=1.
REQ-025 req_valid outside IDLE SHALL be ignored; changes to target outside IDLE SHALL not affect the operation in progress.
REQ-026 A new request SHALL be accepted in the same cycle that done or err is high, since the state is then IDLE.
REQ-027 done and err SHALL never be high in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk, force: state=IDLE, j=0, k=0, done=0, err=0, attempts=0, latched target=0.
REQ-029 Reset mid-operation SHALL abandon the request with no done or err pulse; req_ready=1 after release.
REQ-030 The first accept SHALL be possible on the first rising edge with rst_n high.

Verification (WIDTH=8, MAX_RETRY=3, behavioural JK flop bank on j/k/q_fb)
REQ-031 Hold rst_n low, then pulse clk -> j=k=0x00, done=err=0, req_ready=1.
REQ-032 q=0x00, target=0xA5 -> j=0xA5, k=0x00 for one cycle; done high 2 cycles after accept; attempts=1; q=0xA5.
REQ-033 q=0xFF, target=0x0F -> j=0x00, k=0xF0; done; q=0x0F.
REQ-034 Bit0 of the bank stuck at 0, target=0x01 -> 4 DRIVE cycles each with j=0x01; err pulses at accept+8; attempts=4; no done.
REQ-035 USE_TOGGLE=1, q=0x3C, target=0xC3 -> j=k=0xFF for one cycle; done; q=0xC3.
REQ-036 rst_n driven low mid-cycle during DRIVE -> j=k=0 before the next clk edge; no done/err; a new request is accepted after release.

Source files
------------

// File: rtl/jk_excite_driver.sv
// Drives a bank of JK flip-flops toward a requested value. Each pass is one drive cycle
// followed by one check cycle, with a bounded number of re-drive attempts.
module jk_excite_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [2:0]       attempts
);

  localparam logic [2:0] MaxAttempts = 3'(MAX_RETRY + 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d, err_q, err_d;
  logic [2:0]       attempts_q, attempts_d;

  logic [WIDTH-1:0] drive_tgt, set_bits, clr_bits, j_drv, k_drv;

  // At accept the target is not latched yet, so the live input is used.
  always_comb begin
    drive_tgt = (state_q == StIdle) ? target : target_q;
    set_bits  = drive_tgt & ~q_fb;
    clr_bits  = ~drive_tgt & q_fb;
    if (USE_TOGGLE) begin
      j_drv = set_bits | clr_bits;
      k_drv = set_bits | clr_bits;
    end else begin
      j_drv = set_bits;
      k_drv = clr_bits;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    attempts_d = attempts_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          target_d   = target;
          attempts_d = 3'd1;
          j_d        = j_drv;
          k_d        = k_drv;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (attempts_q < MaxAttempts) begin
          j_d        = j_drv;
          k_d        = k_drv;
          attempts_d = attempts_q + 3'd1;
          state_d    = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      attempts_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      err_q      <= err_d;
      attempts_q <= attempts_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign attempts  = attempts_q;

endmodule
